mem_access_unit: RTL and testbench

- MEM-stage load/store unit of the RV32IM pipeline, directly downstream of the EX-stage ALU.
- Consumes the ALU RESULT as the effective address, plus store data and funct3 from the EX/MEM register.
- Runs a req/ack transaction to data memory, with byte-lane steering and load sign/zero extension.
- Stalls the pipeline with BUSY until the access completes or times out.

---
 rtl/mem_access_unit.sv | 217 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store unit of the RV32IM pipeline.
//
// Takes the EX-stage ALU result as the effective address, runs one req/ack
// transaction to data memory per load/store, steers store bytes onto the
// correct lanes and sign/zero-extends load results. BUSY stalls the pipeline
// while a transaction is outstanding.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word accesses issue no request and pulse
//                the MISALIGN output instead.
//   undefined -> the misalign output is absent; low address bits that do not
//                fit the access size are simply ignored.
//
// Ports:
//   clk, reset_n         pipeline clock (rising edge), async active-low reset
//   address[31:0]        effective address (ALU result)
//   store_data[31:0]     rs2 value for stores
//   funct3[2:0]          access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   mem_read, mem_write  load / store request (store wins if both high)
//   busy                 combinational pipeline stall
//   load_data[31:0]      registered, extended load result
//   load_valid           one-cycle pulse alongside load_data
//   bus_error            one-cycle pulse when a transaction times out
//   dmem_req/we/addr/wdata/be   registered memory request fields
//   dmem_rdata, dmem_ack        memory response
//   misalign             one-cycle trap pulse (MISALIGN_TRAP_EN only)
//   dbg_state            current FSM state (0 = IDLE, 1 = WAIT)
//
// Memory handshake: dmem_req rises with all request fields and holds them
// stable until the cycle dmem_ack is sampled high; the request drops on that
// edge. An ack while no request is outstanding is ignored.

module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16  // legal range 1..255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        busy,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        op_load_q;

    logic        store_ok, load_ok, op_valid, issue, timeout_hit;
    logic [31:0] wdata_c;
    logic [3:0]  be_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_hit;
`endif

    assign dbg_state = (state == S_WAIT);

    // Request decode. Store has priority, so a store with an illegal funct3
    // suppresses a simultaneous load rather than letting the load through.
    always_comb begin
        store_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        load_ok  = store_ok || (funct3 == 3'b100) || (funct3 == 3'b101);
        op_valid = mem_write ? store_ok : (mem_read & load_ok);
`ifdef MISALIGN_TRAP_EN
        misalign_hit = ((funct3[1:0] == 2'b01) && address[0]) ||
                       ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
        issue = op_valid & ~misalign_hit;
`else
        issue = op_valid;
`endif
        timeout_hit = (cnt == 8'(TIMEOUT_CYCLES));
    end

    // Store lane steering: data replicated across lanes, enables pick the lane.
    always_comb begin
        wdata_c = store_data;
        be_c    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata_c = {4{store_data[7:0]}};
                be_c    = 4'b0001 << address[1:0];
            end
            2'b01: begin
                wdata_c = {2{store_data[15:0]}};
                be_c    = address[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_c = store_data;
                be_c    = 4'b1111;
            end
        endcase
    end

    // Load extraction uses the latched address bits and funct3, since the
    // pipeline inputs may have moved on by the time the ack arrives.
    always_comb begin
        byte_sel = 8'(dmem_rdata >> {addr_lo_q, 3'b000});
        half_sel = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Next state and stall. BUSY falls in the ack (or timeout) cycle so the
    // pipeline advances on the same edge that retires the transaction.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = issue;
                if (issue) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (dmem_ack || timeout_hit) state_nxt = S_IDLE;
                else                         busy      = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 8'h0;
            addr_lo_q  <= 2'b00;
            funct3_q   <= 3'b000;
            op_load_q  <= 1'b0;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_be    <= 4'h0;
`ifdef MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else begin
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        cnt        <= 8'h0;
                        addr_lo_q  <= address[1:0];
                        funct3_q   <= funct3;
                        op_load_q  <= ~mem_write;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {address[31:2], 2'b00};
                        dmem_wdata <= mem_write ? wdata_c : 32'h0;
                        dmem_be    <= mem_write ? be_c : 4'b1111;
                    end
`ifdef MISALIGN_TRAP_EN
                    if (op_valid && misalign_hit) misalign <= 1'b1;
`endif
                end
                S_WAIT: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (op_load_q) begin
                            load_data  <= load_ext;
                            load_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        dmem_req  <= 1'b0;
                        bus_error <= 1'b1;
                        load_data <= 32'h0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (default TIMEOUT_CYCLES = 16).
// Inputs change right after the falling edge; outputs are sampled #1 after
// an edge so nothing is read at the active rising edge.

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] address, store_data, dmem_rdata;
    logic [2:0]  funct3;
    logic        mem_read, mem_write, dmem_ack;
    logic        busy, load_valid, bus_error, dmem_req, dmem_we, dbg_state;
    logic [31:0] load_data, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .store_data(store_data),
        .funct3(funct3), .mem_read(mem_read), .mem_write(mem_write), .busy(busy),
        .load_data(load_data), .load_valid(load_valid), .bus_error(bus_error),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack),
`ifdef MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk); #1;
        total++;
        if ({busy, load_data, load_valid, bus_error, dmem_req, dmem_we, dmem_addr,
             dmem_wdata, dmem_be, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%0b ld=%h lv=%0b be=%0b req=%0b we=%0b addr=%h wd=%h ben=%h st=%0b exp all 0",
                     busy, load_data, load_valid, bus_error, dmem_req, dmem_we,
                     dmem_addr, dmem_wdata, dmem_be, dbg_state);
        end
`ifdef MISALIGN_TRAP_EN
        total++;
        if (misalign !== 1'b0) begin
            bad++; $display("FAIL reset_misalign got=%0b exp=0", misalign);
        end
`endif
    endtask

    task automatic test_store_case(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] d, input logic [31:0] exp_wdata,
                                   input logic [3:0] exp_be, input string nm);
        @(negedge clk);
        address = a; store_data = d; funct3 = f3; mem_write = 1'b1;
        #1 total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL %s_busy_idle got=%0b exp=1", nm, busy);
        end
        @(posedge clk); #1 total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !==
            {1'b1, 1'b1, a[31:2], 2'b00, exp_wdata, exp_be}) begin
            bad++;
            $display("FAIL %s_request got req=%0b we=%0b addr=%h wd=%h be=%b exp req=1 we=1 addr=%h wd=%h be=%b",
                     nm, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                     {a[31:2], 2'b00}, exp_wdata, exp_be);
        end
        @(negedge clk);
        mem_write = 1'b0; dmem_ack = 1'b1;
        #1 total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s_busy_ack got=%0b exp=0", nm, busy);
        end
        @(posedge clk); #1 total++;
        if ({dmem_req, load_valid, dbg_state} !== 3'b000) begin
            bad++;
            $display("FAIL %s_done got req=%0b lv=%0b st=%0b exp 0 0 0",
                     nm, dmem_req, load_valid, dbg_state);
        end
        @(negedge clk);
        dmem_ack = 1'b0;
    endtask

    task automatic test_stores();
        test_store_case(3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, "sw");
        test_store_case(3'b000, 32'h0000_2003, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000, "sb_hi");
        test_store_case(3'b000, 32'h0000_2000, 32'hFFFF_FF3C, 32'h3C3C_3C3C, 4'b0001, "sb_lo");
        test_store_case(3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'b1100, "sh_hi");
        test_store_case(3'b001, 32'h0000_2001, 32'h1234_0042, 32'h0042_0042, 4'b0011, "sh_lo");
    endtask

    task automatic test_load_case(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] rdata, input int nwait,
                                  input logic [31:0] exp, input string nm);
        logic [31:0] exp_addr;
        exp_addr = {a[31:2], 2'b00};
        @(negedge clk);
        address = a; funct3 = f3; mem_read = 1'b1;
        #1 total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL %s_busy_idle got=%0b exp=1", nm, busy);
        end
        @(posedge clk); #1 total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, exp_addr, 4'b1111}) begin
            bad++;
            $display("FAIL %s_request got req=%0b we=%0b addr=%h be=%b exp req=1 we=0 addr=%h be=1111",
                     nm, dmem_req, dmem_we, dmem_addr, dmem_be, exp_addr);
        end
        @(negedge clk);
        // Pipeline inputs churn while stalled; the request must not follow them.
        mem_read = 1'b0; address = 32'hFFFF_FFFF; funct3 = 3'b111;
        for (int i = 0; i < nwait; i++) begin
            #1 total++;
            if ({busy, dmem_req, dmem_we, dmem_addr, dmem_be} !==
                {1'b1, 1'b1, 1'b0, exp_addr, 4'b1111}) begin
                bad++;
                $display("FAIL %s_wait%0d got busy=%0b req=%0b we=%0b addr=%h be=%b exp busy=1 req=1 we=0 addr=%h be=1111",
                         nm, i, busy, dmem_req, dmem_we, dmem_addr, dmem_be, exp_addr);
            end
            @(negedge clk);
        end
        dmem_rdata = rdata; dmem_ack = 1'b1;
        #1 total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s_busy_ack got=%0b exp=0", nm, busy);
        end
        @(posedge clk); #1 total++;
        if ({load_valid, load_data, dmem_req, bus_error} !== {1'b1, exp, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL %s_data got lv=%0b data=%h req=%0b berr=%0b exp lv=1 data=%h req=0 berr=0",
                     nm, load_valid, load_data, dmem_req, bus_error, exp);
        end
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(posedge clk); #1 total++;
        if (load_valid !== 1'b0) begin
            bad++; $display("FAIL %s_valid_pulse got=%0b exp=0", nm, load_valid);
        end
    endtask

    task automatic test_loads();
        test_load_case(3'b000, 32'h0000_3002, 32'h12F4_5678, 3, 32'hFFFF_FFF4, "lb");
        test_load_case(3'b100, 32'h0000_3002, 32'h12F4_5678, 3, 32'h0000_00F4, "lbu");
        test_load_case(3'b000, 32'h0000_3001, 32'h12F4_5678, 0, 32'h0000_0056, "lb_pos");
        test_load_case(3'b001, 32'h0000_3002, 32'h8001_5678, 1, 32'hFFFF_8001, "lh");
        test_load_case(3'b101, 32'h0000_3002, 32'h8001_5678, 0, 32'h0000_8001, "lhu");
        test_load_case(3'b001, 32'h0000_3000, 32'h8001_5678, 0, 32'h0000_5678, "lh_lo");
        test_load_case(3'b010, 32'h0000_3000, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, "lw");
`ifndef MISALIGN_TRAP_EN
        test_load_case(3'b010, 32'h0000_3003, 32'h1357_9BDF, 0, 32'h1357_9BDF, "lw_unaligned");
        test_load_case(3'b101, 32'h0000_3003, 32'hABCD_1234, 0, 32'h0000_ABCD, "lhu_unaligned");
`endif
    endtask

    task automatic test_timeout(input logic ack_last, input string nm);
        @(negedge clk);
        address = 32'h0000_5000; funct3 = 3'b010; mem_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1 total++;
            if ({busy, dmem_req, bus_error} !== 3'b110) begin
                bad++;
                $display("FAIL %s_wait%0d got busy=%0b req=%0b berr=%0b exp 1 1 0",
                         nm, k, busy, dmem_req, bus_error);
            end
            @(negedge clk);
        end
        dmem_ack = ack_last; dmem_rdata = 32'h0BAD_F00D;
        #1 total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s_busy_limit got=%0b exp=0", nm, busy);
        end
        @(posedge clk); #1 total++;
        if (ack_last) begin
            if ({bus_error, load_valid, load_data, dmem_req} !== {1'b0, 1'b1, 32'h0BAD_F00D, 1'b0}) begin
                bad++;
                $display("FAIL %s_result got berr=%0b lv=%0b data=%h req=%0b exp berr=0 lv=1 data=0badf00d req=0",
                         nm, bus_error, load_valid, load_data, dmem_req);
            end
        end else begin
            if ({bus_error, load_valid, load_data, dmem_req, dbg_state} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL %s_result got berr=%0b lv=%0b data=%h req=%0b st=%0b exp berr=1 lv=0 data=0 req=0 st=0",
                         nm, bus_error, load_valid, load_data, dmem_req, dbg_state);
            end
        end
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(posedge clk); #1 total++;
        if ({bus_error, load_valid} !== 2'b00) begin
            bad++; $display("FAIL %s_pulse got berr=%0b lv=%0b exp 0 0", nm, bus_error, load_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        address = 32'h0000_6000; funct3 = 3'b010; mem_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1 total++;
        if ({dmem_req, busy, dbg_state} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_immediate got req=%0b busy=%0b st=%0b exp 0 0 0",
                     dmem_req, busy, dbg_state);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
        @(posedge clk); #1 total++;
        if ({load_valid, bus_error, dmem_req} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_quiet got lv=%0b berr=%0b req=%0b exp 0 0 0",
                     load_valid, bus_error, dmem_req);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Stray ack in IDLE must not produce a load result.
        @(posedge clk); #1 total++;
        if ({load_valid, dmem_req, dbg_state} !== 3'b000) begin
            bad++;
            $display("FAIL idle_ack got lv=%0b req=%0b st=%0b exp 0 0 0",
                     load_valid, dmem_req, dbg_state);
        end
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic test_illegal();
        @(negedge clk);
        address = 32'h0000_7000; funct3 = 3'b011; mem_read = 1'b1;
        #1 total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL illegal_load_busy got=%0b exp=0", busy);
        end
        @(posedge clk); #1 total++;
        if ({dmem_req, dbg_state} !== 2'b00) begin
            bad++; $display("FAIL illegal_load_req got req=%0b st=%0b exp 0 0", dmem_req, dbg_state);
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b100;
        #1 total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL illegal_store_busy got=%0b exp=0", busy);
        end
        @(posedge clk); #1 total++;
        if (dmem_req !== 1'b0) begin
            bad++; $display("FAIL illegal_store_req got=%0b exp=0", dmem_req);
        end
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic test_priority();
        @(negedge clk);
        address = 32'h0000_8008; store_data = 32'h0102_0304; funct3 = 3'b010;
        mem_read = 1'b1; mem_write = 1'b1;
        @(posedge clk); #1 total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !==
            {1'b1, 1'b1, 32'h0000_8008, 32'h0102_0304, 4'b1111}) begin
            bad++;
            $display("FAIL priority_request got req=%0b we=%0b addr=%h wd=%h be=%b exp req=1 we=1 addr=00008008 wd=01020304 be=1111",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be);
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
        @(posedge clk); #1 total++;
        if ({load_valid, dmem_req} !== 2'b00) begin
            bad++; $display("FAIL priority_no_load got lv=%0b req=%0b exp 0 0", load_valid, dmem_req);
        end
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign_case(input logic [2:0] f3, input logic [31:0] a, input string nm);
        @(negedge clk);
        address = a; funct3 = f3; mem_read = 1'b1;
        #1 total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s_busy got=%0b exp=0", nm, busy);
        end
        @(posedge clk); #1 total++;
        if ({misalign, dmem_req, load_valid} !== 3'b100) begin
            bad++;
            $display("FAIL %s_trap got mis=%0b req=%0b lv=%0b exp 1 0 0", nm, misalign, dmem_req, load_valid);
        end
        @(negedge clk);
        mem_read = 1'b0;
        @(posedge clk); #1 total++;
        if ({misalign, load_valid, dmem_req} !== 3'b000) begin
            bad++;
            $display("FAIL %s_pulse got mis=%0b lv=%0b req=%0b exp 0 0 0", nm, misalign, load_valid, dmem_req);
        end
    endtask

    task automatic test_misalign();
        test_misalign_case(3'b010, 32'h0000_4001, "mis_lw");
        test_misalign_case(3'b101, 32'h0000_4003, "mis_lhu");
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        address = 32'h0; store_data = 32'h0; funct3 = 3'b000;
        mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_stores();
        test_loads();
        test_timeout(1'b0, "timeout");
        test_timeout(1'b1, "timeout_ack");
        test_reset_mid();
        test_illegal();
        test_priority();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
